// File: rtl/datapath.sv
// Mini-SRC single-bus 32-bit CPU datapath: register file, special registers, ALU, CON logic and RAM.
// RAM powers up all zero and is not affected by clear.
module datapath #(
  parameter int unsigned MEM_DEPTH     = 512,
  parameter              MEM_INIT_FILE = "ram_init.hex"
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        Write,
  input  logic        IncPC,
  input  logic [4:0]  opcode,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        Yin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Inportin,
  input  logic        Outportin,
  input  logic        CONin,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Yout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCout,
  input  logic        MARout,
  input  logic        MDRout,
  input  logic        Inportout,
  input  logic        Outportout,
  input  logic        Cout,
  input  logic [31:0] InPort_input,
  output logic [31:0] bus_out,
  output logic [31:0] OutPort_output,
  output logic        CON_out
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_INC  = 5'b10100;

  logic [31:0]   gpr_q [16];
  logic [31:0]   gpr_d [16];
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [31:0]   mdr_q, mdr_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   y_q, y_d;
  logic [63:0]   z_q, z_d;
  logic [31:0]   inport_q, inport_d;
  logic [31:0]   outport_q, outport_d;
  logic          con_q, con_d;

  logic [31:0]   ram [MEM_DEPTH];
  logic [31:0]   ram_rd;
  logic [31:0]   bus;
  logic [3:0]    reg_sel;
  logic [31:0]   c_sext;
  logic [63:0]   alu_res;
  logic          cond;

  // ---------------------------------------------------------------- RAM
  initial begin
    for (int unsigned i = 0; i < MEM_DEPTH; i++) ram[i] = '0;
  end

  logic unused_init_file;
  assign unused_init_file = |MEM_INIT_FILE;

  // Write stores the MDR value held before this edge, so a same-cycle MDRin cannot leak in.
  always_ff @(posedge Clock) begin
    if (Write) ram[mar_q] <= mdr_q;
  end

  assign ram_rd = ram[mar_q];

  // ------------------------------------------------------- select/encode
  always_comb begin
    reg_sel = '0;
    if (Gra)      reg_sel = ir_q[26:23];
    else if (Grb) reg_sel = ir_q[22:19];
    else if (Grc) reg_sel = ir_q[18:15];
  end

  assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};

  logic unused_ir;
  assign unused_ir = ^ir_q[31:27];

  // ----------------------------------------------------------------- bus
  always_comb begin
    bus = '0;
    if (Rout)            bus = gpr_q[reg_sel];
    else if (BAout)      bus = (reg_sel == 4'd0) ? '0 : gpr_q[reg_sel];
    else if (HIout)      bus = hi_q;
    else if (LOout)      bus = lo_q;
    else if (Zhighout)   bus = z_q[63:32];
    else if (Zlowout)    bus = z_q[31:0];
    else if (PCout)      bus = pc_q;
    else if (MDRout)     bus = mdr_q;
    else if (Inportout)  bus = inport_q;
    else if (Outportout) bus = outport_q;
    else if (Yout)       bus = y_q;
    else if (MARout)     bus = 32'(mar_q);
    else if (Cout)       bus = c_sext;
  end

  assign bus_out = bus;

  // ----------------------------------------------------------------- ALU
  logic [4:0]         shamt;
  logic [63:0]        dbl_r, dbl_l;
  logic signed [63:0] mul_a, mul_b, mul_p;
  logic signed [31:0] div_a, div_b, div_q, div_r;

  always_comb begin
    shamt = bus[4:0];
    dbl_r = {y_q, y_q} >> shamt;
    dbl_l = {y_q, y_q} << shamt;
    mul_a = {{32{y_q[31]}}, y_q};
    mul_b = {{32{bus[31]}}, bus};
    mul_p = mul_a * mul_b;
    div_a = y_q;
    div_b = bus;
    div_q = '0;
    div_r = '0;
    // Most-negative / -1 wraps to itself; handled explicitly so simulation never traps.
    if (div_b == 32'sd0) begin
      div_q = '0;
      div_r = '0;
    end else if (div_a == 32'sh8000_0000 && div_b == -32'sd1) begin
      div_q = div_a;
      div_r = '0;
    end else begin
      div_q = div_a / div_b;
      div_r = div_a % div_b;
    end
  end

  always_comb begin
    alu_res = {32'd0, y_q + bus};
    case (opcode)
      OP_ADD:  alu_res = {32'd0, y_q + bus};
      OP_SUB:  alu_res = {32'd0, y_q - bus};
      OP_AND:  alu_res = {32'd0, y_q & bus};
      OP_OR:   alu_res = {32'd0, y_q | bus};
      OP_SHR:  alu_res = {32'd0, y_q >> shamt};
      OP_SHRA: alu_res = {32'd0, 32'($signed(y_q) >>> shamt)};
      OP_SHL:  alu_res = {32'd0, y_q << shamt};
      OP_ROR:  alu_res = {32'd0, dbl_r[31:0]};
      OP_ROL:  alu_res = {32'd0, dbl_l[63:32]};
      OP_MUL:  alu_res = mul_p;
      OP_DIV:  alu_res = {div_r, div_q};
      OP_NEG:  alu_res = {32'd0, 32'd0 - bus};
      OP_NOT:  alu_res = {32'd0, ~bus};
      OP_INC:  alu_res = {32'd0, bus + 32'd1};
      default: alu_res = {32'd0, y_q + bus};
    endcase
  end

  // ----------------------------------------------------------------- CON
  always_comb begin
    case (ir_q[20:19])
      2'b00:   cond = (bus == 32'd0);
      2'b01:   cond = (bus != 32'd0);
      2'b10:   cond = ~bus[31];
      default: cond = bus[31];
    endcase
  end

  // ------------------------------------------------------ next-state logic
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) gpr_d[i] = gpr_q[i];
    if (Rin) gpr_d[reg_sel] = bus;

    pc_d = pc_q;
    if (IncPC)     pc_d = pc_q + 32'd1;
    else if (PCin) pc_d = bus;

    ir_d      = IRin      ? bus : ir_q;
    mar_d     = MARin     ? bus[AW-1:0] : mar_q;
    hi_d      = HIin      ? bus : hi_q;
    lo_d      = LOin      ? bus : lo_q;
    y_d       = Yin       ? bus : y_q;
    z_d       = Zin       ? alu_res : z_q;
    inport_d  = Inportin  ? InPort_input : inport_q;
    outport_d = Outportin ? bus : outport_q;
    con_d     = CONin     ? cond : con_q;

    mdr_d = mdr_q;
    if (MDRin) mdr_d = Read ? ram_rd : bus;
  end

  // ----------------------------------------------------------- registers
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int unsigned i = 0; i < 16; i++) gpr_q[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= '0;
      z_q       <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      con_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) gpr_q[i] <= gpr_d[i];
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      y_q       <= y_d;
      z_q       <= z_d;
      inport_q  <= inport_d;
      outport_q <= outport_d;
      con_q     <= con_d;
    end
  end

  assign OutPort_output = outport_q;
  assign CON_out        = con_q;

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized bench for the Mini-SRC datapath; ALU results come from an arithmetic reference model.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        clear;
  logic        Read, Write, IncPC;
  logic [4:0]  opcode;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin;
  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout, MDRout, Inportout, Outportout, Cout;
  logic [31:0] InPort_input;
  logic [31:0] bus_out;
  logic [31:0] OutPort_output;
  logic        CON_out;

  int checks = 0;
  int errors = 0;

  datapath dut (
    .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .IncPC(IncPC), .opcode(opcode),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .Inportin(Inportin), .Outportin(Outportin), .CONin(CONin),
    .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MARout(MARout), .MDRout(MDRout), .Inportout(Inportout),
    .Outportout(Outportout), .Cout(Cout), .InPort_input(InPort_input),
    .bus_out(bus_out), .OutPort_output(OutPort_output), .CON_out(CON_out)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    Read = 0; Write = 0; IncPC = 0; opcode = 5'd0;
    Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
    HIin = 0; LOin = 0; Yin = 0; Zin = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0;
    Inportin = 0; Outportin = 0; CONin = 0;
    HIout = 0; LOout = 0; Yout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MARout = 0;
    MDRout = 0; Inportout = 0; Outportout = 0; Cout = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observe the bus with whatever drive strobes the caller has raised.
  task automatic see(input string tag, input logic [31:0] exp);
    #1;
    check(tag, {32'd0, bus_out}, {32'd0, exp});
    idle();
  endtask

  task automatic load_in(input logic [31:0] v);
    InPort_input = v;
    Inportin = 1;
    tick();
  endtask

  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int unsigned s;
    longint p;
    int q, m;
    s = b[4:0];
    r = a;
    case (op)
      5'd4:  return {32'd0, a - b};
      5'd10: return {32'd0, a & b};
      5'd11: return {32'd0, a | b};
      5'd5:  begin for (int unsigned k = 0; k < s; k++) r = r >> 1; return {32'd0, r}; end
      5'd6:  begin for (int unsigned k = 0; k < s; k++) r = {r[31], r[31:1]}; return {32'd0, r}; end
      5'd7:  begin for (int unsigned k = 0; k < s; k++) r = r << 1; return {32'd0, r}; end
      5'd8:  begin for (int unsigned k = 0; k < s; k++) r = {r[0], r[31:1]}; return {32'd0, r}; end
      5'd9:  begin for (int unsigned k = 0; k < s; k++) r = {r[30:0], r[31]}; return {32'd0, r}; end
      5'd15: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
      5'd16: begin
        if (b == 32'd0) return 64'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        m = $signed(a) - q * $signed(b);
        return {m, q};
      end
      5'd17: return {32'd0, 32'd0 - b};
      5'd18: return {32'd0, ~b};
      5'd20: return {32'd0, b + 32'd1};
      default: return {32'd0, a + b};
    endcase
  endfunction

  task automatic alu_run(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    load_in(a);
    Inportout = 1; Yin = 1; tick();
    load_in(b);
    Inportout = 1; Zin = 1; opcode = op; tick();
    Zhighout = 1; see({tag, " hi"}, exp[63:32]);
    Zlowout = 1;  see({tag, " lo"}, exp[31:0]);
  endtask

  logic [4:0]  ops [17] = '{5'd3, 5'd4, 5'd10, 5'd11, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                            5'd15, 5'd16, 5'd17, 5'd18, 5'd20, 5'd0, 5'd12, 5'd31};
  logic [31:0] ra, rb, rv, irv;
  logic [4:0]  rop;
  logic        rexp;

  initial begin
    idle();
    InPort_input = '0;
    clear = 0;
    #12;
    check("reset bus", {32'd0, bus_out}, 64'd0);
    check("reset outport", {32'd0, OutPort_output}, 64'd0);
    check("reset con", {63'd0, CON_out}, 64'd0);
    PCout = 1; see("reset pc", 32'd0);
    clear = 1;
    @(posedge Clock); #1;

    // Place the addi instruction in RAM[0]
    Inportout = 1; MARin = 1; tick();
    load_in(32'h5908_0002);
    Inportout = 1; MDRin = 1; tick();
    Write = 1; tick();
    load_in(32'hDEAD_BEEF);
    Inportout = 1; MDRin = 1; tick();

    // Fetch
    PCout = 1; MARin = 1; tick();
    Read = 1; MDRin = 1; tick();
    MDRout = 1; see("fetch mdr", 32'h5908_0002);
    MDRout = 1; IRin = 1; PCin = 1; IncPC = 1; tick();
    PCout = 1; see("fetch pc", 32'd1);
    Cout = 1; see("cout sext", 32'd2);

    // addi r2,r1,2 with R1=8
    load_in(32'd8);
    Inportout = 1; Grb = 1; Rin = 1; tick();
    Grb = 1; Rout = 1; Yin = 1; tick();
    Cout = 1; Zin = 1; opcode = 5'b00011; tick();
    Zlowout = 1; Gra = 1; Rin = 1; tick();
    Gra = 1; Rout = 1; see("addi r2", 32'h0000_000A);
    Zhighout = 1; see("addi zhi", 32'd0);

    // CON with IR[20:19]=01
    load_in(32'd5);
    Inportout = 1; CONin = 1; tick();
    check("con ne 5", {63'd0, CON_out}, 64'd1);
    load_in(32'd0);
    Inportout = 1; CONin = 1; tick();
    check("con ne 0", {63'd0, CON_out}, 64'd0);

    // PC priority
    load_in(32'h100);
    Inportout = 1; PCin = 1; IncPC = 1; tick();
    PCout = 1; see("incpc prio", 32'd2);
    Inportout = 1; PCin = 1; tick();
    PCout = 1; see("pcin", 32'h100);

    // Simultaneous Write and MDRin
    load_in(32'd5);
    Inportout = 1; MARin = 1; tick();
    load_in(32'hAAAA_0001);
    Inportout = 1; MDRin = 1; tick();
    load_in(32'hBBBB_0002);
    Inportout = 1; MDRin = 1; Write = 1; tick();
    MDRout = 1; see("mdr new", 32'hBBBB_0002);
    Read = 1; MDRin = 1; tick();
    MDRout = 1; see("ram old mdr", 32'hAAAA_0001);

    // MAR zero extension
    load_in(32'hFFFF_FFFF);
    Inportout = 1; MARin = 1; tick();
    MARout = 1; see("mar zext", 32'h0000_01FF);

    // HI/LO/Y and bus priority
    load_in(32'h1234_5678);
    Inportout = 1; HIin = 1; tick();
    load_in(32'h9ABC_DEF0);
    Inportout = 1; LOin = 1; Yin = 1; tick();
    HIout = 1; see("hi", 32'h1234_5678);
    LOout = 1; see("lo", 32'h9ABC_DEF0);
    HIout = 1; LOout = 1; Yout = 1; see("prio hi>lo", 32'h1234_5678);
    LOout = 1; Inportout = 1; see("prio lo>in", 32'h9ABC_DEF0);
    Yout = 1; MARout = 1; see("prio y>mar", 32'h9ABC_DEF0);
    Inportout = 1; Outportout = 1; see("prio in>out", 32'h9ABC_DEF0);

    // R0 and BAout
    load_in(32'd0);
    Inportout = 1; IRin = 1; tick();
    load_in(32'd7);
    Inportout = 1; Grb = 1; Rin = 1; tick();
    Grb = 1; BAout = 1; see("baout r0", 32'd0);
    Grb = 1; Rout = 1; see("rout r0", 32'd7);
    Rout = 1; see("no sel r0", 32'd7);

    // Outport
    load_in(32'h55);
    Inportout = 1; Outportin = 1; tick();
    check("outport", {32'd0, OutPort_output}, 64'h55);

    // Directed ALU points
    alu_run("mul", 5'b01111, 32'hFFFF_FFFA, 32'd4, 64'hFFFF_FFFF_FFFF_FFE8);
    alu_run("div", 5'b10000, 32'hFFFF_FFFA, 32'd4, 64'hFFFF_FFFE_FFFF_FFFF);
    alu_run("div0", 5'b10000, 32'd77, 32'd0, 64'd0);
    alu_run("shra", 5'b00110, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
    alu_run("ror", 5'b01000, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
    alu_run("rol", 5'b01001, 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0003);
    alu_run("shl", 5'b00111, 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0002);
    alu_run("shr0", 5'b00101, 32'h8000_0001, 32'd32, 64'h0000_0000_8000_0001);

    // Randomized ALU against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = ops[$urandom_range(0, 16)];
      ra  = $urandom;
      rb  = $urandom;
      if (i % 4 == 0) rb = rb & 32'hFFFF_FFE0;
      if (i % 10 == 5) rb = 32'd0;
      alu_run($sformatf("alu%0d op%0d", i, rop), rop, ra, rb, alu_ref(rop, ra, rb));
    end

    // Randomized CON conditions
    for (int i = 0; i < 12; i++) begin
      irv = $urandom;
      rv  = (i % 3 == 0) ? 32'd0 : $urandom;
      load_in(irv);
      Inportout = 1; IRin = 1; tick();
      load_in(rv);
      Inportout = 1; CONin = 1; tick();
      case (irv[20:19])
        2'b00:   rexp = (rv == 0);
        2'b01:   rexp = (rv != 0);
        2'b10:   rexp = (rv < 32'h8000_0000);
        default: rexp = (rv >= 32'h8000_0000);
      endcase
      check($sformatf("con%0d", i), {63'd0, CON_out}, {63'd0, rexp});
    end

    // Reset mid-instruction clears registers but keeps RAM
    load_in(32'd1);
    Inportout = 1; CONin = 1; Outportin = 1; tick();
    #2 clear = 0;
    #1;
    check("midrst outport", {32'd0, OutPort_output}, 64'd0);
    check("midrst con", {63'd0, CON_out}, 64'd0);
    PCout = 1; see("midrst pc", 32'd0);
    Zlowout = 1; see("midrst z", 32'd0);
    Rout = 1; see("midrst r0", 32'd0);
    clear = 1;
    @(posedge Clock); #1;
    Read = 1; MDRin = 1; tick();
    MDRout = 1; see("ram kept 0", 32'h5908_0002);
    load_in(32'd5);
    Inportout = 1; MARin = 1; tick();
    Read = 1; MDRin = 1; tick();
    MDRout = 1; see("ram kept 5", 32'hAAAA_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
